collision_predictor: RTL and testbench

Per-frame predictor for the pong AI/paddle logic. Samples the ball's top-left position once per frame on the vsync-start strobe and derives the ball's direction from the previous sample. While the ball travels left, it computes the y at which the ball will reach the left collision plane, including reflections off the top and bottom walls. Sits between the ball-motion block and the left-paddle controller.

---
 rtl/pong_pkg.sv | 19 +
 rtl/bounce_folder.sv | 76 +++++++
 rtl/collision_predictor.sv | 115 +++++++++++
 tb/tb_collision_predictor.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared pong constants, coordinate type and predictor FSM states.
// Imported by collision_predictor and bounce_folder.
package pong_pkg;

  localparam int SCREEN_WIDTH  = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int BALL_SIZE     = 16;

  typedef logic [9:0] coord_t;

  localparam coord_t LEFT_X = 10'd0;
  localparam coord_t Y_MAX  = 10'(SCREEN_HEIGHT - BALL_SIZE);

  typedef enum logic {
    IDLE,
    CALC
  } state_e;

endpackage

// File: rtl/bounce_folder.sv
// Iterative wall-reflection walker: one wall leg per clock.
// Ports: clk_i, rst_i, start_i, y_i/up_i/rem_i (load), done_o, y_o.
module bounce_folder
  import pong_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [9:0] y_i,
  input  logic       up_i,
  input  logic [9:0] rem_i,
  output logic       done_o,
  output logic [9:0] y_o
);

  logic   busy_q, busy_d;
  logic   up_q, up_d;
  coord_t y_q, y_d;
  coord_t rem_q, rem_d;
  coord_t room;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      up_q   <= 1'b0;
      y_q    <= '0;
      rem_q  <= '0;
    end else begin
      busy_q <= busy_d;
      up_q   <= up_d;
      y_q    <= y_d;
      rem_q  <= rem_d;
    end
  end

  always_comb begin
    busy_d = busy_q;
    up_d   = up_q;
    y_d    = y_q;
    rem_d  = rem_q;
    done_o = 1'b0;
    y_o    = y_q;
    room   = Y_MAX - y_q;
    if (start_i) begin
      busy_d = 1'b1;
      up_d   = up_i;
      y_d    = y_i;
      rem_d  = rem_i;
    end else if (busy_q) begin
      if (up_q) begin
        if (y_q >= rem_q) begin
          y_o    = y_q - rem_q;
          y_d    = y_o;
          done_o = 1'b1;
          busy_d = 1'b0;
        end else begin
          rem_d = rem_q - y_q;
          y_d   = '0;
          up_d  = 1'b0;
        end
      end else begin
        if (room >= rem_q) begin
          y_o    = y_q + rem_q;
          y_d    = y_o;
          done_o = 1'b1;
          busy_d = 1'b0;
        end else begin
          rem_d = rem_q - room;
          y_d   = Y_MAX;
          up_d  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/collision_predictor.sv
// Per-frame left-plane y predictor for the left paddle AI.
// Ports: clock_in, reset_in, vsync_start_in, ball_current_x/y_in, predicted_valid/y_out, ball_move_up_out.
module collision_predictor
  import pong_pkg::*;
(
  input  logic       clock_in,
  input  logic       reset_in,
  input  logic       vsync_start_in,
  input  logic [9:0] ball_current_x_in,
  input  logic [9:0] ball_current_y_in,
  output logic       predicted_valid_out,
  output logic [9:0] predicted_y_out,
  output logic       ball_move_up_out
);

  state_e state_q, state_d;
  logic   vs_q;
  logic   have_q, have_d;
  coord_t px_q, px_d;
  coord_t py_q, py_d;
  logic   up_q, up_d;
  logic   val_q, val_d;
  coord_t pred_q, pred_d;

  logic   trig;
  logic   start;
  logic   up0;
  coord_t rem0;
  logic   done;
  coord_t y_res;

  // Registered strobe copy: one trigger per strobe however long it stays high.
  assign trig = vsync_start_in & ~vs_q;
  assign up0  = ball_current_y_in < py_q;
  assign rem0 = (ball_current_x_in > LEFT_X) ?
                (ball_current_x_in - LEFT_X) : '0;

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      vs_q    <= 1'b0;
      have_q  <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      up_q    <= 1'b0;
      val_q   <= 1'b0;
      pred_q  <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= vsync_start_in;
      have_q  <= have_d;
      px_q    <= px_d;
      py_q    <= py_d;
      up_q    <= up_d;
      val_q   <= val_d;
      pred_q  <= pred_d;
    end
  end

  always_comb begin
    state_d = state_q;
    have_d  = have_q;
    px_d    = px_q;
    py_d    = py_q;
    up_d    = up_q;
    val_d   = val_q;
    pred_d  = pred_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          px_d   = ball_current_x_in;
          py_d   = ball_current_y_in;
          have_d = 1'b1;
          if (have_q) begin
            if (ball_current_y_in < py_q)
              up_d = 1'b1;
            else if (ball_current_y_in > py_q)
              up_d = 1'b0;
            if (ball_current_x_in < px_q) begin
              start   = 1'b1;
              state_d = CALC;
            end else begin
              val_d = 1'b0;
            end
          end
        end
      end
      CALC: begin
        if (done) begin
          pred_d  = y_res;
          val_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  bounce_folder u_fold (
    .clk_i   (clock_in),
    .rst_i   (reset_in),
    .start_i (start),
    .y_i     (ball_current_y_in),
    .up_i    (up0),
    .rem_i   (rem0),
    .done_o  (done),
    .y_o     (y_res)
  );

  assign predicted_valid_out = val_q;
  assign predicted_y_out     = pred_q;
  assign ball_move_up_out    = up_q;

endmodule

// File: tb/tb_collision_predictor.sv
// Randomized self-checking bench for collision_predictor.
// Reference model folds the straight-line travel into the wall band.
module tb_collision_predictor;

  localparam int YM = 464;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vs  = 1'b0;
  logic [9:0] bx  = '0;
  logic [9:0] by  = '0;
  logic       valid;
  logic [9:0] pred;
  logic       up;

  int nvec = 0;
  int nerr = 0;

  bit m_have, m_valid, m_up;
  int m_px, m_py, m_pred;

  always #5 clk = ~clk;

  collision_predictor dut (
    .clock_in            (clk),
    .reset_in            (rst),
    .vsync_start_in      (vs),
    .ball_current_x_in   (bx),
    .ball_current_y_in   (by),
    .predicted_valid_out (valid),
    .predicted_y_out     (pred),
    .ball_move_up_out    (up)
  );

  // Unfold walls: travel on a line, then map back by mirror symmetry.
  function automatic int fold(int y, bit dir_up, int rem);
    int p, m;
    p = dir_up ? y - rem : y + rem;
    m = ((p % (2 * YM)) + 2 * YM) % (2 * YM);
    return (m > YM) ? 2 * YM - m : m;
  endfunction

  task automatic model_reset();
    m_have = 0; m_valid = 0; m_up = 0;
    m_px = 0; m_py = 0; m_pred = 0;
  endtask

  task automatic model_frame(int x, int y);
    if (m_have) begin
      if (y < m_py) m_up = 1;
      else if (y > m_py) m_up = 0;
      if (x < m_px) begin
        m_pred  = fold(y, y < m_py, x);
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
    end
    m_have = 1; m_px = x; m_py = y;
  endtask

  task automatic frame(int x, int y, int len);
    @(posedge clk); #1;
    bx = 10'(x); by = 10'(y); vs = 1'b1;
    repeat (len) @(posedge clk);
    #1 vs = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    model_frame(x, y);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    nvec++;
    if (valid !== 1'b0) begin
      nerr++; $display("FAIL reset_valid got %0b want 0", valid);
    end
    nvec++;
    if (pred !== 10'd0) begin
      nerr++; $display("FAIL reset_pred got %0d want 0", pred);
    end
    nvec++;
    if (up !== 1'b0) begin
      nerr++; $display("FAIL reset_up got %0b want 0", up);
    end
  endtask

  task automatic test_up_left();
    int lat;
    frame(460, 150, 1);
    nvec++;
    if (valid !== 1'b0) begin
      nerr++; $display("FAIL first_valid got %0b want 0", valid);
    end
    @(posedge clk); #1;
    bx = 10'd458; by = 10'd148; vs = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    for (int i = 1; i <= 6; i++) begin
      if (lat == 0) begin
        @(posedge clk); #1;
        if (valid === 1'b1) lat = i;
      end
    end
    vs = 1'b0;
    model_frame(458, 148);
    nvec++;
    if (lat == 0) begin
      nerr++; $display("FAIL latency got none want <=6");
    end
    repeat (4) @(posedge clk);
    #1;
    nvec++;
    if (pred !== 10'd310 || m_pred != 310) begin
      nerr++; $display("FAIL upleft_pred got %0d want 310", pred);
    end
    nvec++;
    if (up !== 1'b1) begin
      nerr++; $display("FAIL upleft_up got %0b want 1", up);
    end
    frame(456, 146, 1);
    nvec++;
    if (valid !== 1'b1 || pred !== 10'd310) begin
      nerr++; $display("FAIL upleft2 got %0b/%0d want 1/310", valid, pred);
    end
  endtask

  task automatic test_down_bounce();
    frame(100, 400, 1);
    frame(98, 402, 1);
    nvec++;
    if (valid !== 1'b1 || pred !== 10'd428) begin
      nerr++; $display("FAIL down_pred got %0b/%0d want 1/428", valid, pred);
    end
    nvec++;
    if (up !== 1'b0) begin
      nerr++; $display("FAIL down_up got %0b want 0", up);
    end
  endtask

  task automatic test_plane();
    frame(4, 200, 1);
    frame(0, 198, 1);
    nvec++;
    if (valid !== 1'b1 || pred !== 10'd198) begin
      nerr++; $display("FAIL plane got %0b/%0d want 1/198", valid, pred);
    end
    frame(2, 196, 1);
    nvec++;
    if (valid !== 1'b0 || up !== 1'b1) begin
      nerr++; $display("FAIL right got v%0b u%0b want v0 u1", valid, up);
    end
  endtask

  task automatic test_long_strobe();
    frame(300, 300, 1);
    frame(298, 298, 3);
    nvec++;
    if (valid !== 1'b1 || pred !== 10'(m_pred)) begin
      nerr++;
      $display("FAIL long_strobe got %0b/%0d want 1/%0d", valid, pred, m_pred);
    end
  endtask

  task automatic test_reset_mid_calc();
    frame(1000, 10, 1);
    @(posedge clk); #1;
    bx = 10'd990; by = 10'd400; vs = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    nvec++;
    if (valid !== 1'b0 || pred !== 10'd0 || up !== 1'b0) begin
      nerr++;
      $display("FAIL midcalc_rst got %0b/%0d/%0b want 0/0/0", valid, pred, up);
    end
    vs = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    frame(500, 200, 1);
    nvec++;
    if (valid !== 1'b0) begin
      nerr++; $display("FAIL after_rst1 got %0b want 0", valid);
    end
    frame(490, 190, 1);
    nvec++;
    if (valid !== 1'b1 || pred !== 10'(m_pred)) begin
      nerr++;
      $display("FAIL after_rst2 got %0b/%0d want 1/%0d", valid, pred, m_pred);
    end
  endtask

  task automatic test_random();
    int x, y, len, r;
    for (int n = 0; n < 60; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5 && m_px > 0)
        x = m_px - int'($urandom_range(1, (m_px < 8) ? m_px : 8));
      else
        x = int'($urandom_range(0, 1023));
      if (r == 7) y = 0;
      else if (r == 8) y = YM;
      else y = int'($urandom_range(0, YM));
      len = int'($urandom_range(1, 3));
      frame(x, y, len);
      nvec++;
      if (valid !== m_valid || pred !== 10'(m_pred) || up !== m_up) begin
        nerr++;
        $display("FAIL rand%0d x%0d y%0d got %0b/%0d/%0b want %0b/%0d/%0b",
                 n, x, y, valid, pred, up, m_valid, m_pred, m_up);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_up_left();
    test_down_bounce();
    test_plane();
    test_long_strobe();
    test_reset_mid_calc();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
